// File: rtl/ps2_pkg.sv
// ps2_pkg -- definitions shared by the PS/2 host transmitter and receiver.
//   ps2_state_t        : host-side transfer state encoding
//   DEF_*              : default timing constants in 25 MHz clk cycles
//   max3()             : helper for sizing counters from timing parameters
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_FINISH  = 3'd5
  } ps2_state_t;

  // 100 us clock inhibit, 15 ms start window, 2 ms transfer window at 25 MHz
  localparam int DEF_INHIBIT_CYCLES = 2500;
  localparam int DEF_START_TIMEOUT  = 375000;
  localparam int DEF_XFER_TIMEOUT   = 50000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge -- 2-FF synchronizer for one raw PS/2 pin plus a falling-edge
// detector on the synchronized level.
//   clk, reset : system clock, synchronous active-high reset
//   pin        : raw asynchronous pin level
//   level      : synchronized pin level
//   fall       : one-cycle pulse when the synchronized level goes 1 -> 0
// All flops reset to 1, the idle level of an open-drain PS/2 line, so leaving
// reset never produces a spurious falling edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter.
//   clk, reset       : 25 MHz system clock, synchronous active-high reset
//   start, data      : one-cycle send request and the byte to send
//   ps2c, ps2d       : raw PS/2 clock/data pin levels (asynchronous)
//   ps2c_oe, ps2d_oe : 1 pulls the open-drain line low, 0 releases it
//   busy             : transfer in progress (cycle after accept until done/err)
//   done, err        : one-cycle result pulses (device ack / nack or timeout)
//   fsm_state        : current transfer state, for observation
//
// Handshake: start is a request with no ready; it is accepted only when the
// block is idle (busy low) and ignored otherwise. Exactly one of done/err
// pulses for every accepted start unless reset intervenes.
//
// The open-drain pads live one level up: pin = oe ? 1'b0 : 1'bz.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output ps2_state_t fsm_state
);

  localparam int CNT_MAX = max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX);

  // Counters are loaded with N-1 and count down to zero, giving N cycles.
  localparam logic [CNT_W-1:0] INH_LOAD   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] XFER_LOAD  = CNT_W'(XFER_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic c_level;
  logic c_fall;
  logic d_level;
  logic d_fall_unused;

  ps2_sync_edge u_sync_c (
    .clk   (clk),
    .reset (reset),
    .pin   (ps2c),
    .level (c_level),
    .fall  (c_fall)
  );

  ps2_sync_edge u_sync_d (
    .clk   (clk),
    .reset (reset),
    .pin   (ps2d),
    .level (d_level),
    .fall  (d_fall_unused)
  );

  ps2_state_t       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [3:0]       idx_q, idx_n;
  logic [8:0]       frame_q, frame_n;   // {parity, data}
  logic             c_oe_q, c_oe_n;
  logic             d_oe_q, d_oe_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic             watching;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      frame_q <= frame_n;
      c_oe_q  <= c_oe_n;
      d_oe_q  <= d_oe_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Next-state and registered-output logic. Line enables are registered so
  // the pins never glitch and every change lands the cycle after its cause.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    frame_n  = frame_q;
    c_oe_n   = c_oe_q;
    d_oe_n   = d_oe_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    err_n    = 1'b0;
    watching = 1'b0;

    case (state_q)
      ST_IDLE: begin
        c_oe_n = 1'b0;
        d_oe_n = 1'b0;
        busy_n = 1'b0;
        if (start) begin
          state_n = ST_INHIBIT;
          frame_n = {~^data, data};
          cnt_n   = INH_LOAD;
          idx_n   = '0;
          c_oe_n  = 1'b1;
          busy_n  = 1'b1;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == '0) begin
          state_n = ST_REQ;
          cnt_n   = START_LOAD;
          c_oe_n  = 1'b0;
          d_oe_n  = 1'b1;     // start bit: data held low
        end else begin
          cnt_n = cnt_q - CNT_ONE;
        end
      end

      ST_REQ: begin
        watching = 1'b1;
        cnt_n    = cnt_q - CNT_ONE;
        if (c_fall) begin
          state_n = ST_SHIFT;
          cnt_n   = XFER_LOAD;
          d_oe_n  = ~frame_q[0];
          idx_n   = 4'd1;
        end
      end

      ST_SHIFT: begin
        watching = 1'b1;
        cnt_n    = cnt_q - CNT_ONE;
        if (c_fall) begin
          if (idx_q == 4'd9) begin
            d_oe_n  = 1'b0;   // stop bit: line released
            state_n = ST_ACK;
          end else begin
            d_oe_n = ~frame_q[idx_q];
            idx_n  = idx_q + 4'd1;
          end
        end
      end

      ST_ACK: begin
        watching = 1'b1;
        cnt_n    = cnt_q - CNT_ONE;
        if (c_fall) begin
          state_n = ST_FINISH;
          c_oe_n  = 1'b0;
          d_oe_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = ~d_level;
          err_n   = d_level;
        end
      end

      ST_FINISH: begin
        // the result pulse is registered on entry and lasts this one cycle
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase

    // Expiry overrides any edge seen in the same cycle; the counter sticks
    // at zero instead of wrapping.
    if (watching && cnt_q == '0) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      c_oe_n  = 1'b0;
      d_oe_n  = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b1;
    end
  end

  assign ps2c_oe   = c_oe_q;
  assign ps2d_oe   = d_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed bench for ps2_host_tx with a PS/2 device model.
// The bus is modelled as a wired-AND of the device drive and the host enables.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 2500;
  localparam int STO = 5000;
  localparam int XTO = 50000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #20 clk = ~clk;   // 25 MHz

  logic       reset;
  logic       start;
  logic [7:0] data;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2c;
  logic       ps2d;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       busy;
  logic       done;
  logic       err;
  ps2_state_t fsm_state;

  assign ps2c = dev_clk & ~ps2c_oe;
  assign ps2d = dev_data & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .XFER_TIMEOUT   (XTO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (data),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .ps2c_oe   (ps2c_oe),
    .ps2d_oe   (ps2d_oe),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // ---------------- monitors ----------------
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cl_cnt = 0;
  int err_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (ps2c_oe) cl_cnt <= cl_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] seen;
  logic [10:0] exp_frame;
  int          start_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input logic [7:0] d);
    @(negedge clk);
    data  = d;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  // Device side of one host-to-device frame: waits for the request-to-send,
  // then generates n_fe clock pulses sampling data on each rising edge.
  // seen = {stop, parity, d7..d0, start}. With n_fe < 11 it stops half a
  // period after falling edge n_fe, leaving the clock low.
  task automatic dev_xfer(input int half, input bit ack, input int n_fe,
                          output logic [10:0] frame);
    int guard;
    frame = '0;
    guard = 0;
    while (!(ps2d_oe && !ps2c_oe) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("req_seen", guard < 20000, 1);
    if (guard >= 20000) return;
    repeat (40) @(negedge clk);
    frame[0] = ps2d;
    for (int k = 1; k <= n_fe; k++) begin
      dev_clk = 1'b0;
      repeat (half) @(negedge clk);
      if (k == n_fe && n_fe < 11) return;
      dev_clk = 1'b1;
      if (k <= 10) frame[k] = ps2d;
      if (k == 10) dev_data = ack ? 1'b0 : 1'b1;
      repeat (half) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("idle_reached", guard < 500, 1);
    repeat (5) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] par_data[3];
  logic       par_exp[3];
  int d0, e0, c0, lat;

  initial begin
    par_data = '{8'h01, 8'hFF, 8'h00};
    par_exp  = '{1'b0, 1'b1, 1'b1};

    reset    = 1'b1;
    start    = 1'b0;
    data     = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ps2c_oe", ps2c_oe, 0);
    check("rst_ps2d_oe", ps2d_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_state_idle", fsm_state == ST_IDLE, 1);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xED at 12.5 kHz device clock with ack
    d0 = done_cnt; e0 = err_cnt; c0 = cl_cnt;
    exp_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
    fork
      dev_xfer(1000, 1'b1, 11, seen);
      begin
        do_start(8'hED);
        check("busy_after_start", busy, 1);
      end
    join
    wait_idle();
    exp_frame = exp_q.pop_front();
    check("frame_ED", seen, exp_frame);
    check("inhibit_cycles_ED", cl_cnt - c0, INH);
    check("done_ED", done_cnt - d0, 1);
    check("err_ED", err_cnt - e0, 0);
    check("busy_end_ED", busy, 0);
    check("ps2c_oe_end_ED", ps2c_oe, 0);
    check("ps2d_oe_end_ED", ps2d_oe, 0);

    // parity corner bytes, faster device clock
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt; e0 = err_cnt;
      exp_q.push_back({1'b1, par_exp[i], par_data[i], 1'b0});
      fork
        dev_xfer(50, 1'b1, 11, seen);
        do_start(par_data[i]);
      join
      wait_idle();
      exp_frame = exp_q.pop_front();
      check("frame_parity", seen, exp_frame);
      check("done_parity", done_cnt - d0, 1);
      check("err_parity", err_cnt - e0, 0);
    end

    // device leaves data high at the ack clock
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back({1'b1, 1'b1, 8'h3C, 1'b0});
    fork
      dev_xfer(50, 1'b0, 11, seen);
      do_start(8'h3C);
    join
    wait_idle();
    exp_frame = exp_q.pop_front();
    check("frame_nack", seen, exp_frame);
    check("err_nack", err_cnt - e0, 1);
    check("done_nack", done_cnt - d0, 0);
    check("ps2c_oe_nack", ps2c_oe, 0);
    check("ps2d_oe_nack", ps2d_oe, 0);

    // device never clocks -> start timeout
    d0 = done_cnt; e0 = err_cnt;
    do_start(8'h55);
    begin
      int guard;
      guard = 0;
      while (err_cnt == e0 && guard < INH + STO + 200) begin
        @(negedge clk);
        guard++;
      end
    end
    check("to_err_seen", err_cnt - e0, 1);
    lat = err_cyc - start_cyc;
    check("to_latency_window", (lat >= INH + STO - 2) && (lat <= INH + STO + 2), 1);
    check("to_done", done_cnt - d0, 0);
    check("to_ps2c_oe", ps2c_oe, 0);
    check("to_ps2d_oe", ps2d_oe, 0);
    check("to_busy", busy, 0);
    repeat (10) @(negedge clk);

    // second start during SHIFT is ignored
    d0 = done_cnt; e0 = err_cnt; c0 = cl_cnt;
    exp_q.push_back({1'b1, 1'b1, 8'hA5, 1'b0});
    fork
      dev_xfer(50, 1'b1, 11, seen);
      begin
        do_start(8'hA5);
        repeat (INH + 40 + 400) @(negedge clk);
        check("in_shift", fsm_state == ST_SHIFT, 1);
        do_start(8'h3C);
      end
    join
    wait_idle();
    exp_frame = exp_q.pop_front();
    check("frame_second_start", seen, exp_frame);
    check("done_second_start", done_cnt - d0, 1);
    check("inhibit_once", cl_cnt - c0, INH);
    repeat (50) @(negedge clk);
    check("no_restart_busy", busy, 0);

    // reset after falling edge 5
    fork
      dev_xfer(50, 1'b1, 5, seen);
      do_start(8'h96);
    join
    d0 = done_cnt; e0 = err_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ps2c_oe", ps2c_oe, 0);
    check("midrst_ps2d_oe", ps2d_oe, 0);
    check("midrst_busy", busy, 0);
    reset    = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_err", err_cnt - e0, 0);

    d0 = done_cnt;
    exp_q.push_back({1'b1, 1'b1, 8'h5A, 1'b0});
    fork
      dev_xfer(50, 1'b1, 11, seen);
      do_start(8'h5A);
    join
    wait_idle();
    exp_frame = exp_q.pop_front();
    check("frame_after_rst", seen, exp_frame);
    check("done_after_rst", done_cnt - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
